// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO word packer.
package fifo_pkg;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      LAST = 2'd1,
      OUT  = 2'd2
   } packer_state_e;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_BYTES  = 4;

   // Width of a counter that must hold 0..bytes inclusive.
   function automatic int cnt_width(input int bytes);
      return $clog2(bytes + 1);
   endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Pops BYTES narrow FIFO entries and presents them as one wide word, lane 0 first.
// Define PACKER_FLUSH_EN to add the flush input and out_bytes output for partial words.
module fifo_word_packer
   import fifo_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int BYTES  = DEFAULT_BYTES   // legal range 2..8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          fifo_empty,
   input  logic                          fifo_full,
   input  logic                          fifo_wr_en,
   input  logic [DATA_W-1:0]             fifo_rd_data,
   output logic                          fifo_rd_en,
`ifdef PACKER_FLUSH_EN
   input  logic                          flush,
   output logic [cnt_width(BYTES)-1:0]   out_bytes,
`endif
   output logic [DATA_W*BYTES-1:0]       out_data,
   output logic                          out_valid,
   input  logic                          out_ready
);

   localparam int CNT_W = cnt_width(BYTES);
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(BYTES);
   localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(BYTES - 1);

   packer_state_e    state_q, state_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] captured_q, captured_d;
   logic             inflight_q;
   logic [DATA_W-1:0] lane_q [BYTES];

   logic write_wins;
   logic grant;
   logic handshake;
   logic flush_go;

   // The FIFO services a write before a read in the same cycle.
   assign write_wins = fifo_wr_en & ~fifo_full;
   assign handshake  = (state_q == OUT) & out_ready;

`ifdef PACKER_FLUSH_EN
   assign flush_go  = flush && (state_q == FILL) && (captured_q == issued_q) && (captured_q != '0);
   assign out_bytes = captured_q;
`else
   assign flush_go  = 1'b0;
`endif

   always_comb begin
      fifo_rd_en = 1'b0;
      if (!rst && (state_q == FILL) && (issued_q < FULL_CNT) &&
          !fifo_empty && !write_wins && !flush_go) begin
         fifo_rd_en = 1'b1;
      end
   end

   assign grant = fifo_rd_en;

   // NOTE: every variable written here gets a default first, so no path leaves a latch.
   always_comb begin
      state_d    = state_q;
      issued_d   = issued_q;
      captured_d = captured_q;
      if (inflight_q) begin
         captured_d = captured_q + CNT_W'(1);
      end
      case (state_q)
         FILL: begin
            if (grant) begin
               issued_d = issued_q + CNT_W'(1);
               if (issued_q == LAST_ISSUE) begin
                  state_d = LAST;
               end
            end else if (flush_go) begin
               state_d = OUT;
            end
         end
         LAST: begin
            if (inflight_q) begin
               state_d = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               state_d    = FILL;
               issued_d   = '0;
               captured_d = '0;
            end
         end
         default: begin
            state_d    = FILL;
            issued_d   = '0;
            captured_d = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FILL;
         issued_q   <= '0;
         captured_q <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         issued_q   <= issued_d;
         captured_q <= captured_d;
         inflight_q <= grant;
      end
   end

   // Read data arrives one cycle after its grant and lands in the next free lane.
   for (genvar k = 0; k < BYTES; k++) begin : g_lane
      // NOTE: lanes are reset because out_data must read zero after reset and in flushed words.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            lane_q[k] <= '0;
         end else if (handshake) begin
            lane_q[k] <= '0;
         end else if (inflight_q && (captured_q == CNT_W'(k))) begin
            lane_q[k] <= fifo_rd_data;
         end
      end
      assign out_data[k*DATA_W +: DATA_W] = lane_q[k];
   end

   assign out_valid = (state_q == OUT);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a small behavioural FIFO; flush cases need PACKER_FLUSH_EN.
module tb_fifo_word_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [7:0]  fifo_rd_data = 8'h00;
   logic        fifo_rd_en;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
`ifdef PACKER_FLUSH_EN
   logic        flush;
   logic [2:0]  out_bytes;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mem [64];
   int wr_ptr = 0;
   int rd_ptr = 0;

   always #5 clk = ~clk;

   fifo_word_packer dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
`ifdef PACKER_FLUSH_EN
      .flush        (flush),
      .out_bytes    (out_bytes),
`endif
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready)
   );

   // Behavioural FIFO: a granted read presents data on the following cycle.
   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (fifo_rd_en && !fifo_empty && !(fifo_wr_en && !fifo_full)) begin
         fifo_rd_data <= mem[rd_ptr];
         rd_ptr       <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr      = wr_ptr + 1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; iteration 0 is the current cycle. Counts grants until out_valid.
   task automatic run_word(input string tag, input int budget, output int grants,
                           output int first_g, output int last_g, output int valid_at);
      grants   = 0;
      first_g  = -1;
      last_g   = -1;
      valid_at = -1;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (out_valid) begin
            valid_at = i;
            break;
         end
         if (fifo_rd_en) begin
            if (first_g < 0) first_g = i;
            last_g = i;
            grants = grants + 1;
         end
         @(negedge clk);
      end
      if (valid_at < 0) check({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   int g, fg, lg, va, vcnt;

   initial begin
      rst        = 1'b1;
      fifo_full  = 1'b0;
      fifo_wr_en = 1'b0;
      out_ready  = 1'b1;
`ifdef PACKER_FLUSH_EN
      flush      = 1'b0;
`endif

      // Reset values, and no pop while reset is held even with data waiting.
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      #1;
      check("rst_rd_en", fifo_rd_en, 0);

      // Basic word: four back-to-back pops, valid two cycles after the last grant, for one cycle.
      @(negedge clk);
      rst = 1'b0;
      run_word("w1", 40, g, fg, lg, va);
      check("w1_first_grant", fg, 0);
      check("w1_grants", g, 4);
      check("w1_back_to_back", lg - fg, 3);
      check("w1_latency", va - lg, 2);
      check("w1_data", out_data, 32'h44332211);
`ifdef PACKER_FLUSH_EN
      check("w1_out_bytes", out_bytes, 4);
`endif
      @(negedge clk);
      #1;
      check("w1_valid_one_cycle", out_valid, 0);

      // Backpressure: word held with no pops while stalled, then the second word.
      out_ready = 1'b0;
      for (int b = 1; b <= 8; b++) push(8'(b));
      run_word("w2", 40, g, fg, lg, va);
      check("w2_grants", g, 4);
      check("w2_data", out_data, 32'h04030201);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         check("w2_hold_valid", out_valid, 1);
         check("w2_hold_data", out_data, 32'h04030201);
         check("w2_hold_rd_en", fifo_rd_en, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      run_word("w3", 40, g, fg, lg, va);
      check("w3_first_grant", fg, 0);
      check("w3_data", out_data, 32'h08070605);
      @(negedge clk);

      // A winning write blocks the second pop attempt; that cycle is not counted.
      push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
      #1;
      check("wr_first_pop", fifo_rd_en, 1);
      @(negedge clk);
      fifo_wr_en = 1'b1;
      #1;
      check("wr_wins_block", fifo_rd_en, 0);
      @(negedge clk);
      fifo_wr_en = 1'b0;
      run_word("wr", 40, g, fg, lg, va);
      check("wr_grants", g, 3);
      check("wr_data", out_data, 32'hA3A2A1A0);
      @(negedge clk);

      // Asynchronous reset with two bytes captured; next word restarts at lane 0.
      push(8'h61); push(8'h62);
      repeat (4) @(negedge clk);
      push(8'h71); push(8'h72); push(8'h73); push(8'h74);
      #1;
      rst = 1'b1;
      #1;
      check("arst_data", out_data, 0);
      check("arst_valid", out_valid, 0);
      check("arst_rd_en", fifo_rd_en, 0);
      @(negedge clk);
      rst = 1'b0;
      run_word("arst", 40, g, fg, lg, va);
      check("arst_first_grant", fg, 0);
      check("arst_grants", g, 4);
      check("arst_data_word", out_data, 32'h74737271);
      @(negedge clk);

      // FIFO runs dry after two bytes; word completes only once the remaining two arrive.
      push(8'h81); push(8'h82);
      vcnt = 0;
      g    = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (out_valid) vcnt = vcnt + 1;
         if (fifo_rd_en) g = g + 1;
         @(negedge clk);
      end
      check("dry_no_valid", vcnt, 0);
      check("dry_grants", g, 2);
      push(8'h83); push(8'h84);
      run_word("dry", 40, g, fg, lg, va);
      check("dry_grants_rest", g, 2);
      check("dry_latency", va - lg, 2);
      check("dry_data", out_data, 32'h84838281);
      @(negedge clk);

`ifdef PACKER_FLUSH_EN
      // Flush with nothing captured is ignored; flush of three bytes zero-fills the top lane.
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_empty", out_valid, 0);
      @(negedge clk);
      push(8'hA1); push(8'hB2); push(8'hC3);
      repeat (6) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_valid", out_valid, 1);
      check("flush_data", out_data, 32'h00C3B2A1);
      check("flush_bytes", out_bytes, 3);
      @(negedge clk);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
